// File: rtl/imm_ext_stage.sv
// Registered RV32I/RV64I immediate extender with opcode auto-decode and illegal tagging.
// Results are buffered in a small FIFO so execute-side stalls do not back up into fetch.
module imm_ext_stage #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 0,
    parameter int DEPTH       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [2:0] FMT_I        = 3'b000;
    localparam logic [2:0] FMT_S        = 3'b001;
    localparam logic [2:0] FMT_B        = 3'b010;
    localparam logic [2:0] FMT_U        = 3'b011;
    localparam logic [2:0] FMT_J        = 3'b100;
    localparam logic [2:0] FMT_AUTO_ILL = 3'b111;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] imm_mem [DEPTH];
    logic [2:0]      fmt_mem [DEPTH];
    logic            ill_mem [DEPTH];

    logic [2:0]      fmt_dec;
    logic            illegal_dec;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    logic            push, pop;

    // Format selection: either trusted from the decoder or derived from the opcode.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        fmt_dec = imm_src;
        if (AUTO_DECODE != 0) begin
            unique case (inst[6:0])
                7'b0010011, 7'b0000011,
                7'b1100111, 7'b1110011: fmt_dec = FMT_I;
                7'b0100011:             fmt_dec = FMT_S;
                7'b1100011:             fmt_dec = FMT_B;
                7'b0110111, 7'b0010111: fmt_dec = FMT_U;
                7'b1101111:             fmt_dec = FMT_J;
                default:                fmt_dec = FMT_AUTO_ILL;
            endcase
        end
    end

    assign illegal_dec = (fmt_dec > FMT_J);

    always_comb begin
        imm32 = '0;
        unique case (fmt_dec)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_x = XLEN'($signed(imm32));

    // Ready depends only on occupancy: a pop while full does not free a slot this cycle.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: payload storage is not reset; count and pointers alone decide what is visible.
        if (push && !rst) begin
            imm_mem[wr_ptr_q] <= illegal_dec ? '0 : imm_x;
            fmt_mem[wr_ptr_q] <= fmt_dec;
            ill_mem[wr_ptr_q] <= illegal_dec;
        end
    end

    assign out_imm     = out_valid ? imm_mem[rd_ptr_q] : '0;
    assign out_fmt     = out_valid ? fmt_mem[rd_ptr_q] : 3'b000;
    assign out_illegal = out_valid ? ill_mem[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: three configurations share one stimulus stream and are
// compared against queue-based reference models plus directed known-answer cases.
module tb_imm_ext_stage;
    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready;
    logic [31:0] inst;
    logic [2:0]  imm_src;

    logic        r32, v32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        r64, v64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ra, va, illa;
    logic [31:0] imma;
    logic [2:0]  fmta;

    int n_checks = 0;
    int n_pass   = 0;

    imm_ext_stage #(.XLEN(32), .AUTO_DECODE(0), .DEPTH(2)) u_m32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32), .inst(inst),
        .imm_src(imm_src), .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32));

    imm_ext_stage #(.XLEN(64), .AUTO_DECODE(0), .DEPTH(2)) u_m64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64), .inst(inst),
        .imm_src(imm_src), .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64));

    imm_ext_stage #(.XLEN(32), .AUTO_DECODE(1), .DEPTH(4)) u_auto (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ra), .inst(inst),
        .imm_src(imm_src), .out_valid(va), .out_ready(out_ready), .out_imm(imma),
        .out_fmt(fmta), .out_illegal(illa));

    // Reference model: immediates are computed as signed integer values of the
    // scattered bit fields, then truncated to the configured width.
    function automatic logic [2:0] auto_fmt(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73: return 3'd0;
            7'h23:                      return 3'd1;
            7'h63:                      return 3'd2;
            7'h37, 7'h17:               return 3'd3;
            7'h6F:                      return 3'd4;
            default:                    return 3'd7;
        endcase
    endfunction

    function automatic ent_t model_ext(input logic [31:0] i, input logic [2:0] src,
                                       input int xlen, input bit auto_dec);
        ent_t        e;
        longint      v;
        logic [63:0] vv;
        e.fmt = auto_dec ? auto_fmt(i[6:0]) : src;
        e.ill = (e.fmt > 3'd4);
        case (e.fmt)
            3'd0:    v = longint'($signed(i[31:20]));
            3'd1:    v = longint'($signed({i[31:25], i[11:7]}));
            3'd2:    v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd3:    v = longint'($signed({i[31:12], 12'h000}));
            3'd4:    v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: v = 0;
        endcase
        vv = v;
        e.imm = (xlen == 32) ? {32'h0, vv[31:0]} : vv;
        return e;
    endfunction

    ent_t q32[$], q64[$], qa[$];

    always @(posedge clk) begin
        bit p, o;
        if (rst) begin
            q32.delete(); q64.delete(); qa.delete();
        end else begin
            p = in_valid && (q32.size() != 2); o = out_ready && (q32.size() != 0);
            if (o) void'(q32.pop_front());
            if (p) q32.push_back(model_ext(inst, imm_src, 32, 1'b0));
            p = in_valid && (q64.size() != 2); o = out_ready && (q64.size() != 0);
            if (o) void'(q64.pop_front());
            if (p) q64.push_back(model_ext(inst, imm_src, 64, 1'b0));
            p = in_valid && (qa.size() != 4); o = out_ready && (qa.size() != 0);
            if (o) void'(qa.pop_front());
            if (p) qa.push_back(model_ext(inst, imm_src, 32, 1'b1));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] i, input logic [2:0] s);
        in_valid = 1'b1; inst = i; imm_src = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        pulse_rst();
        n_checks++;
        if ({v32, r32, imm32, fmt32, ill32} !== {1'b0, 1'b1, 32'h0, 3'b000, 1'b0})
            $display("FAIL reset_m32: got %h want %h", {v32, r32, imm32, fmt32, ill32}, {1'b0, 1'b1, 32'h0, 3'b000, 1'b0});
        else n_pass++;
        n_checks++;
        if ({v64, r64, imm64, fmt64, ill64} !== {1'b0, 1'b1, 64'h0, 3'b000, 1'b0})
            $display("FAIL reset_m64: got %h want %h", {v64, r64, imm64, fmt64, ill64}, {1'b0, 1'b1, 64'h0, 3'b000, 1'b0});
        else n_pass++;
        n_checks++;
        if ({va, ra, imma, fmta, illa} !== {1'b0, 1'b1, 32'h0, 3'b000, 1'b0})
            $display("FAIL reset_auto: got %h want %h", {va, ra, imma, fmta, illa}, {1'b0, 1'b1, 32'h0, 3'b000, 1'b0});
        else n_pass++;
    endtask

    task automatic test_i_type();
        pulse_rst();
        push_one(32'hFFF00093, 3'b000);
        n_checks++;
        if ({v32, imm32, fmt32, ill32} !== {1'b1, 32'hFFFF_FFFF, 3'b000, 1'b0})
            $display("FAIL i_type_m32: got %h want %h", {v32, imm32, fmt32, ill32}, {1'b1, 32'hFFFF_FFFF, 3'b000, 1'b0});
        else n_pass++;
        n_checks++;
        if ({v64, imm64} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF})
            $display("FAIL i_type_m64: got %h want %h", {v64, imm64}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        else n_pass++;
        n_checks++;
        if ({va, imma, fmta, illa} !== {1'b1, 32'hFFFF_FFFF, 3'b000, 1'b0})
            $display("FAIL i_type_auto: got %h want %h", {va, imma, fmta, illa}, {1'b1, 32'hFFFF_FFFF, 3'b000, 1'b0});
        else n_pass++;
    endtask

    task automatic test_b_j();
        pulse_rst();
        push_one(32'hFE000EE3, 3'b010);
        push_one(32'hFF9FF06F, 3'b100);
        n_checks++;
        if ({v32, imm32, fmt32, ill32} !== {1'b1, 32'hFFFF_FFFC, 3'b010, 1'b0})
            $display("FAIL b_type_m32: got %h want %h", {v32, imm32, fmt32, ill32}, {1'b1, 32'hFFFF_FFFC, 3'b010, 1'b0});
        else n_pass++;
        n_checks++;
        if ({va, imma, fmta, illa} !== {1'b1, 32'hFFFF_FFFC, 3'b010, 1'b0})
            $display("FAIL b_type_auto: got %h want %h", {va, imma, fmta, illa}, {1'b1, 32'hFFFF_FFFC, 3'b010, 1'b0});
        else n_pass++;
        tick();
        n_checks++;
        if ({v32, imm32, fmt32} !== {1'b1, 32'hFFFF_FFFC, 3'b010})
            $display("FAIL stall_stable: got %h want %h", {v32, imm32, fmt32}, {1'b1, 32'hFFFF_FFFC, 3'b010});
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if ({v32, imm32, fmt32, ill32} !== {1'b1, 32'hFFFF_FFF8, 3'b100, 1'b0})
            $display("FAIL j_type_m32: got %h want %h", {v32, imm32, fmt32, ill32}, {1'b1, 32'hFFFF_FFF8, 3'b100, 1'b0});
        else n_pass++;
        n_checks++;
        if ({v64, imm64, fmt64} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 3'b100})
            $display("FAIL j_type_m64: got %h want %h", {v64, imm64, fmt64}, {1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 3'b100});
        else n_pass++;
        n_checks++;
        if ({va, imma, fmta, illa} !== {1'b1, 32'hFFFF_FFF8, 3'b100, 1'b0})
            $display("FAIL j_type_auto: got %h want %h", {va, imma, fmta, illa}, {1'b1, 32'hFFFF_FFF8, 3'b100, 1'b0});
        else n_pass++;
    endtask

    task automatic test_u64();
        pulse_rst();
        push_one(32'h800000B7, 3'b011);
        n_checks++;
        if ({v64, imm64, fmt64, ill64} !== {1'b1, 64'hFFFF_FFFF_8000_0000, 3'b011, 1'b0})
            $display("FAIL u_type_m64: got %h want %h", {v64, imm64, fmt64, ill64}, {1'b1, 64'hFFFF_FFFF_8000_0000, 3'b011, 1'b0});
        else n_pass++;
        n_checks++;
        if ({v32, imm32, fmta} !== {1'b1, 32'h8000_0000, 3'b011})
            $display("FAIL u_type_m32: got %h want %h", {v32, imm32, fmta}, {1'b1, 32'h8000_0000, 3'b011});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        pulse_rst();
        in_valid = 1'b1; imm_src = 3'b000; inst = 32'h00100013;
        tick();
        n_checks++;
        if (r32 !== 1'b1) $display("FAIL bp_ready_one: got %b want 1", r32); else n_pass++;
        inst = 32'h00200013;
        tick();
        inst = 32'h00300013;
        n_checks++;
        if (r32 !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", r32); else n_pass++;
        tick();
        n_checks++;
        if ({r32, v32, imm32} !== {1'b0, 1'b1, 32'd1})
            $display("FAIL bp_held: got %h want %h", {r32, v32, imm32}, {1'b0, 1'b1, 32'd1});
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({r32, v32, imm32} !== {1'b1, 1'b1, 32'd2})
            $display("FAIL bp_pop_full: got %h want %h", {r32, v32, imm32}, {1'b1, 1'b1, 32'd2});
        else n_pass++;
        tick();
        n_checks++;
        if ({r32, v32, imm32} !== {1'b1, 1'b1, 32'd3})
            $display("FAIL bp_third: got %h want %h", {r32, v32, imm32}, {1'b1, 1'b1, 32'd3});
        else n_pass++;
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({v32, v64} !== 2'b00) $display("FAIL bp_drained: got %b want 00", {v32, v64}); else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        pulse_rst();
        push_one(32'h002081B3, 3'b110);
        n_checks++;
        if ({v32, imm32, fmt32, ill32} !== {1'b1, 32'h0, 3'b110, 1'b1})
            $display("FAIL illegal_m32: got %h want %h", {v32, imm32, fmt32, ill32}, {1'b1, 32'h0, 3'b110, 1'b1});
        else n_pass++;
        n_checks++;
        if ({v64, imm64, fmt64, ill64} !== {1'b1, 64'h0, 3'b110, 1'b1})
            $display("FAIL illegal_m64: got %h want %h", {v64, imm64, fmt64, ill64}, {1'b1, 64'h0, 3'b110, 1'b1});
        else n_pass++;
        n_checks++;
        if ({va, imma, fmta, illa} !== {1'b1, 32'h0, 3'b111, 1'b1})
            $display("FAIL illegal_auto: got %h want %h", {va, imma, fmta, illa}, {1'b1, 32'h0, 3'b111, 1'b1});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pulse_rst();
        push_one(32'h00100013, 3'b000);
        push_one(32'h00200013, 3'b000);
        n_checks++;
        if ({v32, r32} !== 2'b10) $display("FAIL rm_queued: got %b want 10", {v32, r32}); else n_pass++;
        rst = 1'b1; in_valid = 1'b1; inst = 32'h00500013; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if ({v32, r32, imm32, fmt32, ill32} !== {1'b0, 1'b1, 32'h0, 3'b000, 1'b0})
            $display("FAIL rm_m32: got %h want %h", {v32, r32, imm32, fmt32, ill32}, {1'b0, 1'b1, 32'h0, 3'b000, 1'b0});
        else n_pass++;
        n_checks++;
        if ({v64, r64, va, ra, imm64} !== {1'b0, 1'b1, 1'b0, 1'b1, 64'h0})
            $display("FAIL rm_others: got %h want %h", {v64, r64, va, ra, imm64}, {1'b0, 1'b1, 1'b0, 1'b1, 64'h0});
        else n_pass++;
        tick();
        n_checks++;
        if ({v32, v64, va} !== 3'b000) $display("FAIL rm_push_dropped: got %b want 000", {v32, v64, va}); else n_pass++;
    endtask

    task automatic test_random();
        logic [6:0]  ops [9] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        logic [31:0] r;
        logic [6:0]  op;
        int          idx;
        ent_t        h;
        logic [37:0] e32, ea;
        logic [69:0] e64;
        pulse_rst();
        for (int n = 0; n < 600; n++) begin
            r   = $urandom();
            idx = $urandom_range(0, 9);
            op  = (idx == 9) ? r[6:0] : ops[idx];
            inst      = {r[31:7], op};
            imm_src   = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            e32 = {1'b0, 1'b1, 32'h0, 3'b000, 1'b0};
            e64 = {1'b0, 1'b1, 64'h0, 3'b000, 1'b0};
            ea  = {1'b0, 1'b1, 32'h0, 3'b000, 1'b0};
            if (q32.size() != 0) begin h = q32[0]; e32 = {1'b1, q32.size() != 2, h.imm[31:0], h.fmt, h.ill}; end
            if (q64.size() != 0) begin h = q64[0]; e64 = {1'b1, q64.size() != 2, h.imm, h.fmt, h.ill}; end
            if (qa.size() != 0)  begin h = qa[0];  ea  = {1'b1, qa.size() != 4, h.imm[31:0], h.fmt, h.ill}; end
            n_checks++;
            if ({v32, r32, imm32, fmt32, ill32} !== e32)
                $display("FAIL rand_m32 cyc %0d: got %h want %h", n, {v32, r32, imm32, fmt32, ill32}, e32);
            else n_pass++;
            n_checks++;
            if ({v64, r64, imm64, fmt64, ill64} !== e64)
                $display("FAIL rand_m64 cyc %0d: got %h want %h", n, {v64, r64, imm64, fmt64, ill64}, e64);
            else n_pass++;
            n_checks++;
            if ({va, ra, imma, fmta, illa} !== ea)
                $display("FAIL rand_auto cyc %0d: got %h want %h", n, {va, ra, imma, fmta, illa}, ea);
            else n_pass++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inst = '0; imm_src = '0;
        test_reset();
        test_i_type();
        test_b_j();
        test_u64();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
